sevenseg_capture: RTL

Monitor that sits on the far side of the lab seven-segment interface. It samples the time-multiplexed anode/cathode/dp lines driven by a student Top design and rebuilds the eight displayed characters as hex nibbles plus raw segment patterns. The outputs feed the VIO probe inputs, so a bench or a remote user can read back what the display shows instead of the raw scan lines.

---
 rtl/sevenseg_pkg.sv | 50 +++++
 rtl/seg_sync.sv | 25 ++
 rtl/sevenseg_capture.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/sevenseg_pkg.sv
// Shared types for the seven-segment capture monitor: glyph table, FSM states
// and the segment-to-hex decoder.
package sevenseg_pkg;

  typedef logic [6:0] seg_t;

  // Active-high segment patterns, bit order {g,f,e,d,c,b,a}
  localparam seg_t GLYPH_0 = 7'h3F;
  localparam seg_t GLYPH_1 = 7'h06;
  localparam seg_t GLYPH_2 = 7'h5B;
  localparam seg_t GLYPH_3 = 7'h4F;
  localparam seg_t GLYPH_4 = 7'h66;
  localparam seg_t GLYPH_5 = 7'h6D;
  localparam seg_t GLYPH_6 = 7'h7D;
  localparam seg_t GLYPH_7 = 7'h07;
  localparam seg_t GLYPH_8 = 7'h7F;
  localparam seg_t GLYPH_9 = 7'h6F;
  localparam seg_t GLYPH_A = 7'h77;
  localparam seg_t GLYPH_B = 7'h7C;
  localparam seg_t GLYPH_C = 7'h39;
  localparam seg_t GLYPH_D = 7'h5E;
  localparam seg_t GLYPH_E = 7'h79;
  localparam seg_t GLYPH_F = 7'h71;

  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, HOLD} state_t;

  // Returns {valid, nibble}; anything that is not one of the 16 glyphs is {0, 0}
  function automatic logic [4:0] seg_to_hex(input seg_t seg);
    case (seg)
      GLYPH_0: return 5'h10;
      GLYPH_1: return 5'h11;
      GLYPH_2: return 5'h12;
      GLYPH_3: return 5'h13;
      GLYPH_4: return 5'h14;
      GLYPH_5: return 5'h15;
      GLYPH_6: return 5'h16;
      GLYPH_7: return 5'h17;
      GLYPH_8: return 5'h18;
      GLYPH_9: return 5'h19;
      GLYPH_A: return 5'h1A;
      GLYPH_B: return 5'h1B;
      GLYPH_C: return 5'h1C;
      GLYPH_D: return 5'h1D;
      GLYPH_E: return 5'h1E;
      GLYPH_F: return 5'h1F;
      default: return 5'h00;
    endcase
  endfunction

endpackage

// File: rtl/seg_sync.sv
// Two-flop synchronizer for the asynchronous scan lines; the reset value lets
// the lines power up looking idle rather than looking like every anode is low.
module seg_sync #(
  parameter int WIDTH = 16,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] synced
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta   <= RESET_VAL;
      synced <= RESET_VAL;
    end else begin
      meta   <= raw;
      synced <= meta;
    end
  end

endmodule

// File: rtl/sevenseg_capture.sv
// Rebuilds the eight displayed characters from the multiplexed anode/cathode/dp
// scan lines and reports frame completion, anode conflicts and a stale display.
module sevenseg_capture
  import sevenseg_pkg::*;
#(
  parameter int         SETTLE_CYCLES = 4,
  parameter int         STALE_CYCLES  = 1000000,
  parameter logic [7:0] DIGIT_MASK    = 8'hFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  anode,
  input  logic [6:0]  cathode,
  input  logic        dp,
  output logic [31:0] digits,
  output logic [7:0]  digit_valid,
  output logic [55:0] seg_raw,
  output logic [7:0]  dp_out,
  output logic        frame_done,
  output logic        multi_anode,
  output logic        stale
);

  localparam logic [15:0] IDLE_LINES  = 16'hFFFF;
  localparam logic [7:0]  SETTLE_MAX  = 8'(SETTLE_CYCLES);
  localparam logic [31:0] STALE_LIMIT = 32'(STALE_CYCLES);

  logic [15:0] lines;
  logic [15:0] prev_lines;
  logic [7:0]  active;
  seg_t        cath_s;
  logic        dp_s;
  logic        changed;
  logic [7:0]  settle_cnt;
  logic [7:0]  settle_next;
  logic        settled;
  logic [23:0] stale_cnt;
  logic [7:0]  seen;
  logic [7:0]  seen_set;
  logic        frame_hit;
  logic [2:0]  digit_idx;
  logic [4:0]  decoded;
  logic        capture;
  logic        flag_multi;
  state_t      state;
  state_t      state_next;

  seg_sync #(
    .WIDTH    (16),
    .RESET_VAL(IDLE_LINES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   ({anode, cathode, dp}),
    .synced(lines)
  );

  assign active  = ~lines[15:8];
  assign cath_s  = lines[7:1];
  assign dp_s    = lines[0];
  assign changed = (lines != prev_lines);
  assign decoded = seg_to_hex(~cath_s);

  always_comb begin
    settle_next = settle_cnt;
    if (changed)
      settle_next = '0;
    else if (settle_cnt != SETTLE_MAX)
      settle_next = settle_cnt + 8'd1;
  end

  // Deciding on the count this cycle reaches keeps capture at 2 + SETTLE + 1 cycles
  assign settled = (settle_next == SETTLE_MAX);

  always_comb begin
    digit_idx = '0;
    for (int i = 0; i < 8; i++)
      if (active[i]) digit_idx = 3'(i);
  end

  always_comb begin
    state_next = state;
    capture    = 1'b0;
    flag_multi = 1'b0;
    case (state)
      IDLE:
        if (active != 8'h00) state_next = SETTLE;
      SETTLE:
        if (settled) begin
          if (active == 8'h00) begin
            state_next = IDLE;
          end else if ($onehot(active)) begin
            state_next = CAPTURE;
            capture    = 1'b1;
          end else begin
            state_next = HOLD;
            flag_multi = 1'b1;
          end
        end
      CAPTURE, HOLD:
        if (changed)
          state_next = (active == 8'h00) ? IDLE : SETTLE;
        else
          state_next = HOLD;
      default:
        state_next = IDLE;
    endcase
  end

  // The completing capture's bit is absorbed by the clear, never carried over
  assign seen_set  = seen | (capture ? (8'b1 << digit_idx) : 8'b0);
  assign frame_hit = ((seen_set & DIGIT_MASK) == DIGIT_MASK);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      prev_lines  <= IDLE_LINES;
      settle_cnt  <= '0;
      stale_cnt   <= '0;
      seen        <= '0;
      frame_done  <= 1'b0;
      multi_anode <= 1'b0;
    end else begin
      state      <= state_next;
      prev_lines <= lines;
      settle_cnt <= settle_next;
      seen       <= frame_hit ? 8'b0 : seen_set;
      frame_done <= frame_hit;
      if (capture)
        stale_cnt <= '0;
      else if (stale_cnt != '1)
        stale_cnt <= stale_cnt + 24'd1;
      if (flag_multi)
        multi_anode <= 1'b1;
    end
  end

  // Digit registers load on the edge that enters CAPTURE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits      <= '0;
      digit_valid <= '0;
      seg_raw     <= '0;
      dp_out      <= '0;
    end else if (capture) begin
      seg_raw[digit_idx*7 +: 7]   <= ~cath_s;
      dp_out[digit_idx]           <= ~dp_s;
      digits[digit_idx*4 +: 4]    <= decoded[3:0];
      digit_valid[digit_idx]      <= decoded[4];
    end
  end

  assign stale = ({8'd0, stale_cnt} >= STALE_LIMIT);

endmodule
